// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: walks a validated address window of the pattern memory,
// fetching each entry and holding it on the LEDs for a programmable number of cycles.
module led_pattern_sequencer #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 5,
  parameter int DIV_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_start_addr,
  input  logic [ADDR_W-1:0] cfg_end_addr,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              pause,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] leds,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [ADDR_W-1:0] start_r, end_r;
  logic [1:0]        mode_r;
  logic [DIV_W-1:0]  div_r, cnt_r, cnt_s;
  logic              dir_r, dir_s;   // 0 = up, 1 = down
  logic [DATA_W-1:0] leds_r;
  logic              done_r, done_s, err_r, err_s;
  logic              latch_s, load_s, window_ok_s;

  // next-state, address stepping and pulse decode
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    dir_s       = dir_r;
    cnt_s       = cnt_r;
    latch_s     = 1'b0;
    load_s      = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    window_ok_s = (cfg_start_addr <= cfg_end_addr) && ({1'b0, cfg_end_addr} < DEPTH_X);

    case (state_r)
      IDLE: begin
        if (cmd_start) begin
          if (window_ok_s) begin
            latch_s = 1'b1;
            addr_s  = cfg_start_addr;
            dir_s   = 1'b0;
            state_s = FETCH;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (cmd_stop) begin
          state_s = IDLE;
        end else begin
          state_s = LOAD;
        end
      end
      LOAD: begin
        if (cmd_stop) begin
          state_s = IDLE;
        end else begin
          load_s  = 1'b1;
          cnt_s   = div_r - DIV_W'(1);
          state_s = HOLD;
        end
      end
      HOLD: begin
        if (cmd_stop) begin
          state_s = IDLE;
        end else if (pause) begin
          cnt_s = cnt_r;
        end else if (cnt_r != {DIV_W{1'b0}}) begin
          cnt_s = cnt_r - DIV_W'(1);
        end else begin
          state_s = FETCH;
          case (mode_r)
            MODE_ONESHOT: begin
              if (addr_r == end_r) begin
                state_s = IDLE;
                done_s  = 1'b1;
              end else begin
                addr_s = addr_r + ADDR_W'(1);
              end
            end
            MODE_PINGPONG: begin
              // endpoints are shown once per turn; a single-entry window stays put
              if (!dir_r) begin
                if (addr_r == end_r) begin
                  dir_s  = 1'b1;
                  addr_s = (start_r == end_r) ? start_r : end_r - ADDR_W'(1);
                end else begin
                  addr_s = addr_r + ADDR_W'(1);
                end
              end else begin
                if (addr_r == start_r) begin
                  dir_s  = 1'b0;
                  addr_s = (start_r == end_r) ? start_r : start_r + ADDR_W'(1);
                end else begin
                  addr_s = addr_r - ADDR_W'(1);
                end
              end
            end
            default: begin
              if (addr_r == end_r) begin
                addr_s = start_r;
              end else begin
                addr_s = addr_r + ADDR_W'(1);
              end
            end
          endcase
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state, configuration and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      start_r <= {ADDR_W{1'b0}};
      end_r   <= {ADDR_W{1'b0}};
      mode_r  <= 2'd0;
      div_r   <= DIV_W'(1);
      cnt_r   <= {DIV_W{1'b0}};
      dir_r   <= 1'b0;
      leds_r  <= {DATA_W{1'b0}};
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      cnt_r   <= cnt_s;
      dir_r   <= dir_s;
      done_r  <= done_s;
      err_r   <= err_s;
      if (latch_s) begin
        start_r <= cfg_start_addr;
        end_r   <= cfg_end_addr;
        mode_r  <= cfg_mode;
        div_r   <= (cfg_div == {DIV_W{1'b0}}) ? DIV_W'(1) : cfg_div;
      end
      if (load_s) begin
        leds_r <= mem_rdata;
      end
    end
  end

  assign mem_rd   = (state_r == FETCH);
  assign mem_addr = (state_r == FETCH) ? addr_r : {ADDR_W{1'b0}};
  assign busy     = (state_r != IDLE);
  assign leds     = leds_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: a small synchronous memory model with
// mem[k]=k+1 feeds the DUT; expected values are hand-derived per cycle.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cfg_start_addr, cfg_end_addr;
  logic [23:0] cfg_div;
  logic [1:0]  cfg_mode;
  logic        cmd_start, cmd_stop, pause;
  logic        mem_rd;
  logic [4:0]  mem_addr, mem_rdata, leds;
  logic        busy, done, err;

  logic [4:0]  mem [32];
  logic [4:0]  mem_q;
  int          checks = 0;
  int          failures = 0;

  led_pattern_sequencer #(.DEPTH(24), .ADDR_W(5), .DATA_W(5), .DIV_W(24)) dut (
    .clk(clk), .rst(rst),
    .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .pause(pause),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .leds(leds), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_q <= mem[mem_addr];
  end
  assign mem_rdata = mem_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [4:0] s, input logic [4:0] e,
                           input logic [23:0] d, input logic [1:0] m);
    cfg_start_addr = s;
    cfg_end_addr   = e;
    cfg_div        = d;
    cfg_mode       = m;
    cmd_start      = 1'b1;
    tick();
    cmd_start      = 1'b0;
  endtask

  task automatic stop_run();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
  endtask

  task automatic cyc(input string tag, input int c, input logic exp_rd, input int exp_addr,
                     input int exp_led, input logic exp_busy, input logic exp_done);
    check($sformatf("%s_rd_c%0d", tag, c), 32'(mem_rd), 32'(exp_rd));
    if (exp_rd) check($sformatf("%s_addr_c%0d", tag, c), 32'(mem_addr), 32'(exp_addr));
    check($sformatf("%s_leds_c%0d", tag, c), 32'(leds), 32'(exp_led));
    check($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(exp_busy));
    check($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(exp_done));
    check($sformatf("%s_err_c%0d", tag, c), 32'(err), 32'd0);
  endtask

  initial begin
    int seq2[5] = '{2, 3, 4, 2, 3};
    int seq4[7] = '{1, 2, 3, 2, 1, 2, 3};
    int seq6[3] = '{5, 6, 5};
    int led;
    for (int k = 0; k < 32; k++) mem[k] = 5'(k + 1);
    mem_q = 5'd0;
    rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; pause = 1'b0;
    cfg_start_addr = 5'd0; cfg_end_addr = 5'd0; cfg_div = 24'd0; cfg_mode = 2'd0;
    tick(); tick();
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      tick();
      cyc("idle", c, 1'b0, 0, 0, 1'b0, 1'b0);
    end

    // loop 2..4, div 3: period 5
    start_run(5'd2, 5'd4, 24'd3, 2'd0);
    for (int c = 0; c < 25; c++) begin
      led = (c < 2) ? 0 : seq2[(c - 2) / 5] + 1;
      cyc("loop", c, (c % 5) == 0, seq2[c / 5], led, 1'b1, 1'b0);
      tick();
    end
    stop_run();
    check("loop_stop_busy", 32'(busy), 32'd0);
    check("loop_stop_rd", 32'(mem_rd), 32'd0);
    check("loop_stop_leds", 32'(leds), 32'd4);

    // one-shot 0..1, div 1: done one cycle after the last hold
    start_run(5'd0, 5'd1, 24'd1, 2'd1);
    for (int c = 0; c < 9; c++) begin
      led = (c < 2) ? 4 : (c < 5) ? 1 : 2;
      cyc("oneshot", c, (c == 0) || (c == 3), (c == 0) ? 0 : 1, led, c < 6, c == 6);
      tick();
    end

    // ping-pong 1..3, div 2: period 4
    start_run(5'd1, 5'd3, 24'd2, 2'd2);
    for (int c = 0; c < 28; c++) begin
      led = (c < 2) ? 2 : seq4[(c - 2) / 4] + 1;
      cyc("pp", c, (c % 4) == 0, seq4[c / 4], led, 1'b1, 1'b0);
      tick();
    end
    stop_run();
    check("pp_stop_busy", 32'(busy), 32'd0);

    // ping-pong single entry window 4..4
    start_run(5'd4, 5'd4, 24'd2, 2'd2);
    for (int c = 0; c < 12; c++) begin
      cyc("pp1", c, (c % 4) == 0, 4, (c < 2) ? 4 : 5, 1'b1, 1'b0);
      tick();
    end
    stop_run();

    // loop 0..2, div 4, pause during the first hold stretches it to 10 cycles
    start_run(5'd0, 5'd2, 24'd4, 2'd0);
    for (int c = 0; c < 25; c++) begin
      led = (c < 2) ? 5 : (c < 14) ? 1 : (c < 20) ? 2 : 3;
      cyc("pause", c, (c == 0) || (c == 12) || (c == 18) || (c == 24),
          (c == 12) ? 1 : (c == 18) ? 2 : 0, led, 1'b1, 1'b0);
      pause = (c >= 3) && (c <= 8);
      tick();
    end
    cmd_stop = 1'b1; cmd_start = 1'b1;
    tick();
    cmd_stop = 1'b0; cmd_start = 1'b0;
    check("stopstart_busy", 32'(busy), 32'd0);
    check("stopstart_leds", 32'(leds), 32'd3);
    check("stopstart_err", 32'(err), 32'd0);
    tick();
    check("stopstart_norestart_busy", 32'(busy), 32'd0);
    check("stopstart_norestart_rd", 32'(mem_rd), 32'd0);
    check("stopstart_norestart_leds", 32'(leds), 32'd3);

    // rejected windows
    start_run(5'd5, 5'd3, 24'd1, 2'd0);
    check("err_order", 32'(err), 32'd1);
    check("err_order_busy", 32'(busy), 32'd0);
    tick();
    check("err_order_pulse", 32'(err), 32'd0);
    start_run(5'd0, 5'd24, 24'd1, 2'd0);
    check("err_depth", 32'(err), 32'd1);
    check("err_depth_busy", 32'(busy), 32'd0);
    tick();
    check("err_depth_pulse", 32'(err), 32'd0);

    // div 0 behaves as div 1: period 3
    start_run(5'd5, 5'd6, 24'd0, 2'd0);
    for (int c = 0; c < 9; c++) begin
      led = (c < 2) ? 3 : seq6[(c - 2) / 3] + 1;
      cyc("div0", c, (c % 3) == 0, seq6[c / 3], led, 1'b1, 1'b0);
      tick();
    end
    stop_run();
    check("div0_stop_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Controller that sequences the LED pattern memory. It walks a configured address window, fetches each entry over a 1-cycle-latency synchronous read port, and drives it to the LEDs.
- Each entry is held for a programmable number of cycles. This replaces the free-running PC walk with loop, one-shot and ping-pong modes, plus start, stop and pause control.
- Sits between the pattern memory and the LED pins, clocked by the system clock.

Parameters:
- DEPTH, 32, number of pattern memory entries.
- ADDR_W, 5, address width; DEPTH <= 2**ADDR_W.
- DATA_W, 5, pattern/LED width.
- DIV_W, 24, width of the hold-count configuration.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_start_addr  in  ADDR_W  first address of the window.
- cfg_end_addr  in  ADDR_W  last address of the window (inclusive).
- cfg_div  in  DIV_W  hold cycles per entry; 0 is treated as 1.
- cfg_mode  in  2  0=loop, 1=one-shot, 2=ping-pong, 3=reserved (treated as loop).
- cmd_start  in  1  single-cycle start request.
- cmd_stop  in  1  single-cycle stop request.
- pause  in  1  level; freezes the hold counter.
- mem_rd  out  1  read strobe to the pattern memory.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W  read data, valid on the cycle after mem_rd.
- leds  out  DATA_W  registered LED drive.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a one-shot run completes.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values:
  - state=IDLE; leds=0; busy=0; done=0; err=0; mem_rd=0; mem_addr=0; dir=up; cnt=0.
- Configuration latching:
  - cfg_* is latched only on an accepted cmd_start.
  - Changes to cfg_* during a run have no effect.
  - Effective hold D = max(cfg_div, 1).
- States: IDLE, FETCH, LOAD, HOLD.
- IDLE:
  - leds hold their last value.
  - On cmd_start, check the window.
  - If cfg_start_addr > cfg_end_addr or cfg_end_addr >= DEPTH: err pulses the next cycle and the block stays in IDLE.
  - Otherwise: latch config, addr=start, dir=up, go to FETCH.
- FETCH:
  - mem_rd=1, mem_addr=addr; both are driven combinationally from state.
  - Always proceeds to LOAD on the next edge.
- LOAD:
  - leds <= mem_rdata; cnt <= D-1; go to HOLD.
- HOLD:
  - If pause=1, cnt is frozen.
  - Else if cnt != 0, cnt decrements.
  - Else the entry ends: compute the next address and go to FETCH, or finish.
- Timing:
  - HOLD lasts exactly D unpaused cycles.
  - Entry period is D+2 cycles.
  - cmd_start sampled at edge N gives leds updated at edge N+2.
- Pause:
  - Only HOLD is affected.
  - FETCH and LOAD always complete regardless of pause.
- Next address at end of an entry:
  - Loop: addr==end gives addr=start; otherwise addr+1.
  - One-shot: addr==end gives state=IDLE and done=1 for one cycle, with leds keeping the final entry; otherwise addr+1.
  - Ping-pong, up: addr==end gives dir=down, addr=end-1 (or start if start==end).
  - Ping-pong, down: addr==start gives dir=up, addr=start+1 (or start if start==end).
  - In ping-pong, endpoints are shown once per turn.
- start==end:
  - Loop and ping-pong repeat the single entry, refetching every D+2 cycles.
  - One-shot shows it once, then pulses done.
- cmd_stop:
  - In any non-IDLE state, the next state is IDLE.
  - leds hold their value; mem_rd=0 from the next cycle; no done pulse.
  - cmd_stop has priority over cmd_start and pause.
- Start while busy:
  - cmd_start is ignored (no restart, no err) unless in IDLE.
  - If cmd_stop and cmd_start arrive together, stop wins and start is dropped.
- rst mid-run:
  - Returns all state and outputs to their reset values on that edge, including leds=0.
- Address arithmetic:
  - ADDR_W wide; no wrap is possible because the window is validated.
- Output registration:
  - done and err are registered.
  - busy is decoded from state.

Test Plan:
- Reset, then idle 10 cycles -> leds=0, busy=0, mem_rd=0 throughout; done and err never assert.
- Loop, start=2, end=4, div=3, mem[k]=k+1 -> mem_addr sequence 2,3,4,2,3 with mem_rd every 5 cycles; leds=3 at edge N+2, then 4, 5, 3, each held 5 cycles.
- One-shot, start=0, end=1, div=1 -> leds 1 then 2, each held 3 cycles; done pulses once exactly 1 cycle after the second entry's hold; busy falls the same edge; leds stay 2.
- Ping-pong, start=1, end=3, div=2 -> address order 1,2,3,2,1,2,3; one more run with start=end=4 shows only address 4 repeatedly.
- Loop div=4 with pause high for 6 cycles in HOLD -> that entry is held 10 cycles, the others 4. Then cmd_stop+cmd_start in the same cycle -> IDLE, busy=0, leds unchanged, no restart.
- cmd_start with start=5, end=3, then with end=DEPTH -> err pulse each time, busy stays 0. Then valid start with div=0 -> behaves identically to div=1 (period 3).
